// File: rtl/bcd_accumulator_ctrl_pkg.sv
// Shared types and seven-segment encoding for the BCD accumulator.
// Segment vectors are active-low and ordered a..g from index 0 to 6.
package bcd_accumulator_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ADD0  = 3'd2,
        ADD1  = 3'd3,
        ADD2  = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    // Non-BCD codes (10..15) render as a blank digit.
    function automatic logic [0:6] digit_to_seg(input logic [3:0] d);
        logic [0:6] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_accumulator_ctrl_digit_add.sv
// Single-digit BCD adder with carry in/out; purely combinational.
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [4:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (raw > 5'd9) begin
            digit = 4'(raw - 5'd10);
            cout  = 1'b1;
        end else begin
            digit = raw[3:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_accumulator_ctrl.sv
// Push-button driven three-digit BCD accumulator; one shared digit adder
// is stepped through ones, tens and hundreds across ADD0..ADD2.
module bcd_accumulator_ctrl
    import bcd_accumulator_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLOCK_50,
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic [0:6] HEX0,
    output logic [0:6] HEX1,
    output logic [0:6] HEX2,
    output logic [0:6] HEX3,
    output logic [0:6] HEX4,
    output logic [0:6] HEX5,
    output logic [9:0] LEDR
);

    logic rst_n;
    assign rst_n = KEY[0];

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   key_prev_q, key_prev_d;
    logic [9:0]             op_q, op_d;
    logic [3:0]             acc0_q, acc0_d, acc1_q, acc1_d, acc2_q, acc2_d;
    logic                   c0_q, c0_d, c1_q, c1_d;
    logic                   err_q, err_d, ovf_q, ovf_d;

    logic       press;
    logic [3:0] add_a, add_b, add_digit;
    logic       add_cin, add_cout;
    logic       sw8_unused;

    assign sw8_unused = op_q[8];

    // Synchronizer presets to 1 (released button), so leaving reset never fakes a press.
    always_comb begin
        sync_d[0] = KEY[1];
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        key_prev_d = sync_q[SYNC_STAGES-1];
    end

    assign press = key_prev_q & ~sync_q[SYNC_STAGES-1];

    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        case (state_q)
            ADD0: begin
                add_a = acc0_q;
                add_b = op_q[3:0];
            end
            ADD1: begin
                add_a   = acc1_q;
                add_b   = op_q[7:4];
                add_cin = c0_q;
            end
            ADD2: begin
                add_a   = acc2_q;
                add_cin = c1_q;
            end
            default: ;
        endcase
    end

    bcd_digit_add u_digit_add (
        .a     (add_a),
        .b     (add_b),
        .cin   (add_cin),
        .digit (add_digit),
        .cout  (add_cout)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc0_d  = acc0_q;
        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = CHECK;
                    op_d    = SW;
                end
            end
            CHECK: begin
                if (op_q[9]) begin
                    acc0_d  = 4'd0;
                    acc1_d  = 4'd0;
                    acc2_d  = 4'd0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end else if (op_q[7:4] > 4'd9 || op_q[3:0] > 4'd9) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    err_d   = 1'b0;
                    state_d = ADD0;
                end
            end
            ADD0: begin
                acc0_d  = add_digit;
                c0_d    = add_cout;
                state_d = ADD1;
            end
            ADD1: begin
                acc1_d  = add_digit;
                c1_d    = add_cout;
                state_d = ADD2;
            end
            ADD2: begin
                acc2_d  = add_digit;
                if (add_cout) begin
                    ovf_d = 1'b1;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync_q     <= '1;
            key_prev_q <= 1'b1;
            op_q       <= '0;
            acc0_q     <= '0;
            acc1_q     <= '0;
            acc2_q     <= '0;
            c0_q       <= 1'b0;
            c1_q       <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            key_prev_q <= key_prev_d;
            op_q       <= op_d;
            acc0_q     <= acc0_d;
            acc1_q     <= acc1_d;
            acc2_q     <= acc2_d;
            c0_q       <= c0_d;
            c1_q       <= c1_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign HEX0 = digit_to_seg(acc0_q);
    assign HEX1 = digit_to_seg(acc1_q);
    assign HEX2 = digit_to_seg(acc2_q);
    assign HEX3 = SEG_BLANK;
    assign HEX4 = digit_to_seg(SW[3:0]);
    assign HEX5 = digit_to_seg(SW[7:4]);
    assign LEDR = {err_q, ovf_q, (state_q != IDLE), 7'b0000000};

endmodule

// File: tb/tb_bcd_accumulator_ctrl.sv
// Randomized scoreboard bench for bcd_accumulator_ctrl against a decimal
// arithmetic model of the accumulator, flags and busy duration.
module tb_bcd_accumulator_ctrl;

    localparam int W = 15;

    logic       clk = 1'b0;
    logic [1:0] key;
    logic [9:0] sw;
    logic [0:6] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0] ledr;

    int errors = 0;
    int checks = 0;

    // Expected entry: {busy_len[2:0], ovf, err, acc[9:0]}
    logic [W-1:0] exp_q[$];

    int   model_acc = 0;
    logic model_err = 1'b0;
    logic model_ovf = 1'b0;

    logic mon_prev_busy = 1'b0;
    int   mon_run = 0;

    // ---------------- clock / reset ----------------
    always #10 clk = ~clk;

    bcd_accumulator_ctrl #(.SYNC_STAGES(2)) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .SW       (sw),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3),
        .HEX4     (hex4),
        .HEX5     (hex5),
        .LEDR     (ledr)
    );

    function automatic logic [0:6] seg_of(input int d);
        case (d)
            0:       return 7'b0000001;
            1:       return 7'b1001111;
            2:       return 7'b0010010;
            3:       return 7'b0000110;
            4:       return 7'b1001100;
            5:       return 7'b0100100;
            6:       return 7'b0100000;
            7:       return 7'b0001111;
            8:       return 7'b0000000;
            9:       return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_display(input string tag, input int acc);
        check({tag, "_hex0"}, int'(hex0), int'(seg_of(acc % 10)));
        check({tag, "_hex1"}, int'(hex1), int'(seg_of((acc / 10) % 10)));
        check({tag, "_hex2"}, int'(hex2), int'(seg_of(acc / 100)));
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_expected(input logic [9:0] s);
        int ones, tens, sum;
        logic [2:0] len;
        ones = int'(s[3:0]);
        tens = int'(s[7:4]);
        if (s[9]) begin
            model_acc = 0;
            model_err = 1'b0;
            model_ovf = 1'b0;
            len = 3'd2;
        end else if (ones > 9 || tens > 9) begin
            model_err = 1'b1;
            len = 3'd1;
        end else begin
            sum = model_acc + tens * 10 + ones;
            if (sum >= 1000) model_ovf = 1'b1;
            model_acc = sum % 1000;
            model_err = 1'b0;
            len = 3'd5;
        end
        exp_q.push_back({len, model_ovf, model_err, 10'(model_acc)});
    endtask

    task automatic wait_busy(input logic level, input int budget, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ledr[7] == level) begin
                seen = 1;
                break;
            end
        end
        check(name, seen, 1);
    endtask

    task automatic do_op(input logic [9:0] s);
        @(negedge clk);
        sw = s;
        #1;
        check("hex4_live", int'(hex4), int'(seg_of(int'(s[3:0]))));
        check("hex5_live", int'(hex5), int'(seg_of(int'(s[7:4]))));
        push_expected(s);
        key[1] = 1'b0;
        wait_busy(1'b1, 10, "busy_start");
        key[1] = 1'b1;
        wait_busy(1'b0, 20, "busy_end");
        repeat (2) @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!key[0]) begin
                mon_prev_busy = 1'b0;
                mon_run = 0;
            end else begin
                if (ledr[7]) begin
                    mon_run++;
                end else if (mon_prev_busy) begin
                    check("pending_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_display("acc", int'(e[9:0]));
                        check("ledr9_err", int'(ledr[9]), int'(e[10]));
                        check("ledr8_ovf", int'(ledr[8]), int'(e[11]));
                        check("busy_len", mon_run, int'(e[14:12]));
                        check("hex3_blank", int'(hex3), 7'h7f);
                        check("ledr_low_zero", int'(ledr[6:0]), 0);
                    end
                    mon_run = 0;
                end
                mon_prev_busy = ledr[7];
            end
        end
    end

    initial begin : watchdog
        #(60000 * 20);
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic [9:0] s;
        int r;
        key = 2'b10;
        sw  = 10'h000;
        repeat (3) @(negedge clk);
        #1;
        check_display("reset", 0);
        check("reset_ledr_flags", int'(ledr[9:7]), 0);
        check("reset_hex3", int'(hex3), 7'h7f);
        key[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("no_press_after_reset", int'(ledr[7]), 0);

        // basic add, carry chain, invalid digits
        do_op(10'h025);
        do_op(10'h200);
        do_op(10'h095);
        do_op(10'h007);
        do_op(10'h200);
        for (int i = 0; i < 10; i++) do_op(10'h095);
        do_op(10'h099);
        do_op(10'h001);
        do_op(10'h03A);
        do_op(10'h0B2);
        do_op(10'h011);

        // second press while ADD1 is in progress must be dropped
        @(negedge clk);
        sw = 10'h012;
        push_expected(10'h012);
        key[1] = 1'b0;
        @(negedge clk);
        key[1] = 1'b1;
        repeat (2) @(negedge clk);
        key[1] = 1'b0;
        wait_busy(1'b0, 20, "ignored_press_busy_end");
        key[1] = 1'b1;
        repeat (10) @(negedge clk);
        check("ignored_press_idle", int'(ledr[7]), 0);

        // clear from 123 after an error
        do_op(10'h200);
        do_op(10'h099);
        do_op(10'h024);
        do_op(10'h0C0);
        do_op(10'h3FF);

        // build 999, then abort a +1 with reset during ADD1
        for (int i = 0; i < 10; i++) do_op(10'h099);
        do_op(10'h009);
        @(negedge clk);
        sw = 10'h001;
        key[1] = 1'b0;
        wait_busy(1'b1, 10, "abort_busy_start");
        repeat (2) @(negedge clk);
        key[0] = 1'b0;
        #1;
        check_display("abort", 0);
        check("abort_ledr_flags", int'(ledr[9:7]), 0);
        model_acc = 0;
        model_err = 1'b0;
        model_ovf = 1'b0;
        key[1] = 1'b1;
        repeat (2) @(negedge clk);
        key[0] = 1'b1;
        repeat (4) @(negedge clk);
        check_display("post_abort", 0);
        check("post_abort_idle", int'(ledr[9:7]), 0);

        // randomized operations
        for (int n = 0; n < 50; n++) begin
            r = $urandom_range(0, 99);
            s = 10'($urandom_range(0, 1023));
            if (r < 10) begin
                s[9] = 1'b1;
            end else if (r < 25) begin
                s[9] = 1'b0;
                if ($urandom_range(0, 1) == 1) s[3:0] = 4'($urandom_range(10, 15));
                else s[7:4] = 4'($urandom_range(10, 15));
            end else begin
                s[9] = 1'b0;
                s[3:0] = 4'($urandom_range(0, 9));
                s[7:4] = 4'($urandom_range(0, 9));
            end
            do_op(s);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
